// File: rtl/cga_idbseq.sv
// -----------------------------------------------------------------------------
// cga_idbseq -- internal data bus (IDB) read sequencer.
//
// Arbitrates up to three level-sensitive read requesters (microcode, interrupt
// logic, panel/debug) with a round-robin pointer. The winner's source code
// selects which IDB source enable is driven low for DRIVE_CYC cycles. The
// muxed bus value is then captured, and a one-cycle ACK (qualified by ERR for
// illegal codes) completes the transfer.
//
// Parameters
//   DRIVE_CYC  cycles the selected source is enabled before capture (1..4)
//
// Ports
//   MCLK        in   system clock, rising edge
//   RESETN      in   asynchronous active-low reset
//   REQ_2_0     in   read requests (bit0 ucode, bit1 irq, bit2 panel)
//   SEL0_2_0    in   source code for requester 0
//   SEL1_2_0    in   source code for requester 1
//   SEL2_2_0    in   source code for requester 2
//   FIDBI_15_0  in   muxed IDB value
//   EPGSN       out  PGS source enable, active low
//   EPCRN       out  PCR source enable, active low
//   EPICSN      out  PICS source enable, active low
//   EPICVN      out  PICV source enable, active low
//   EPICMASKN   out  PICMASK source enable, active low
//   GNT_2_0     out  one-hot grant, DRIVE entry through ACK
//   ACK         out  one-cycle completion pulse
//   ERR         out  qualifies ACK: illegal source code
//   DATA_15_0   out  captured IDB word
//   BUSY        out  high whenever a transfer is in progress
// -----------------------------------------------------------------------------
module cga_idbseq #(
    parameter int unsigned DRIVE_CYC = 1
) (
    input  logic        MCLK,
    input  logic        RESETN,
    input  logic [2:0]  REQ_2_0,
    input  logic [2:0]  SEL0_2_0,
    input  logic [2:0]  SEL1_2_0,
    input  logic [2:0]  SEL2_2_0,
    input  logic [15:0] FIDBI_15_0,
    output logic        EPGSN,
    output logic        EPCRN,
    output logic        EPICSN,
    output logic        EPICVN,
    output logic        EPICMASKN,
    output logic [2:0]  GNT_2_0,
    output logic        ACK,
    output logic        ERR,
    output logic [15:0] DATA_15_0,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter reload value: DRIVE lasts CNT_LOAD+1 cycles.
    localparam logic [1:0] CNT_LOAD = 2'(DRIVE_CYC - 1);

    // Active-low enable vector, bit order {PICMASK, PICV, PICS, PCR, PGS}.
    // External (5) and illegal (6..7) codes enable no internal source.
    function automatic logic [4:0] decode_en_n(input logic [2:0] code);
        logic [4:0] en_n;
        case (code)
            3'd0:    en_n = 5'b11110;
            3'd1:    en_n = 5'b11101;
            3'd2:    en_n = 5'b11011;
            3'd3:    en_n = 5'b10111;
            3'd4:    en_n = 5'b01111;
            default: en_n = 5'b11111;
        endcase
        return en_n;
    endfunction

    function automatic logic code_legal(input logic [2:0] code);
        return (code <= 3'd5);
    endfunction

    // Modulo-3 successor of a requester index.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    function automatic logic req_bit(input logic [2:0] req, input logic [1:0] idx);
        logic b;
        case (idx)
            2'd0:    b = req[0];
            2'd1:    b = req[1];
            2'd2:    b = req[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // Round-robin pick: first requester found scanning ptr, ptr+1, ptr+2.
    // Caller guarantees at least one request bit is set.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] cand;
        logic [1:0] win;
        logic       found;
        cand  = ptr;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && req_bit(req, cand)) begin
                win   = cand;
                found = 1'b1;
            end else begin
                win   = win;
            end
            cand = next_idx(cand);
        end
        return win;
    endfunction

    function automatic logic [2:0] sel_mux(input logic [1:0] idx, input logic [2:0] s0,
                                           input logic [2:0] s1, input logic [2:0] s2);
        logic [2:0] s;
        case (idx)
            2'd0:    s = s0;
            2'd1:    s = s1;
            default: s = s2;
        endcase
        return s;
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  ptr_r,   ptr_s;
    logic [1:0]  cnt_r,   cnt_s;
    logic [1:0]  gidx_r,  gidx_s;
    logic [2:0]  gnt_r,   gnt_s;
    logic [2:0]  sel_r,   sel_s;
    logic [4:0]  en_n_r,  en_n_s;
    logic        ack_r,   ack_s;
    logic        err_r,   err_s;
    logic        busy_r,  busy_s;
    logic [15:0] data_r,  data_s;
    logic [1:0]  win_s;
    logic [2:0]  win_sel_s;

    // Next-state and next-output logic; every output is registered so the
    // enables and handshake leave the block glitch-free.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        gidx_s    = gidx_r;
        gnt_s     = gnt_r;
        sel_s     = sel_r;
        en_n_s    = 5'b11111;
        ack_s     = 1'b0;
        err_s     = 1'b0;
        busy_s    = busy_r;
        data_s    = data_r;
        win_s     = rr_pick(REQ_2_0, ptr_r);
        win_sel_s = sel_mux(win_s, SEL0_2_0, SEL1_2_0, SEL2_2_0);

        case (state_r)
            ST_IDLE: begin
                if (REQ_2_0 != 3'b000) begin
                    // SEL is sampled only here; later changes are ignored.
                    state_s = ST_DRIVE;
                    gidx_s  = win_s;
                    gnt_s   = 3'b001 << win_s;
                    sel_s   = win_sel_s;
                    cnt_s   = CNT_LOAD;
                    en_n_s  = decode_en_n(win_sel_s);
                    busy_s  = 1'b1;
                end else begin
                    gnt_s   = 3'b000;
                    busy_s  = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (cnt_r == 2'd0) begin
                    // Last drive cycle: capture the bus and raise ACK in DONE.
                    state_s = ST_DONE;
                    ack_s   = 1'b1;
                    err_s   = ~code_legal(sel_r);
                    if (code_legal(sel_r)) begin
                        data_s = FIDBI_15_0;
                    end else begin
                        data_s = data_r;
                    end
                end else begin
                    cnt_s  = cnt_r - 2'd1;
                    en_n_s = decode_en_n(sel_r);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                ptr_s   = next_idx(gidx_r);
                gnt_s   = 3'b000;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 3'b000;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without ACK.
    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            cnt_r   <= 2'd0;
            gidx_r  <= 2'd0;
            gnt_r   <= 3'b000;
            sel_r   <= 3'd0;
            en_n_r  <= 5'b11111;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            data_r  <= 16'h0000;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            gidx_r  <= gidx_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            en_n_r  <= en_n_s;
            ack_r   <= ack_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            data_r  <= data_s;
        end
    end

    assign EPGSN     = en_n_r[0];
    assign EPCRN     = en_n_r[1];
    assign EPICSN    = en_n_r[2];
    assign EPICVN    = en_n_r[3];
    assign EPICMASKN = en_n_r[4];
    assign GNT_2_0   = gnt_r;
    assign ACK       = ack_r;
    assign ERR       = err_r;
    assign DATA_15_0 = data_r;
    assign BUSY      = busy_r;

endmodule

// File: doc/cga_idbseq.md
CGA_IDBSEQ -- requirements
Module: cga_idbseq

Interface
REQ-001 Parameters SHALL be:
  DRIVE_CYC, default 1, number of MCLK cycles the selected IDB source is enabled before capture (legal 1..4).
REQ-002 Ports SHALL be:
  MCLK  in  1  system clock; all state updates on the rising edge.
  RESETN  in  1  reset; asynchronous, active-low.
  REQ_2_0  in  3  read requests, level; bit0 microcode, bit1 interrupt logic, bit2 panel/debug.
  SEL0_2_0, SEL1_2_0, SEL2_2_0  in  3 each  IDB source code per requester: 0 PGS, 1 PCR, 2 PICS, 3 PICV, 4 PICMASK, 5 external XFIDBI, 6..7 illegal.
  FIDBI_15_0  in  16  muxed IDB value.
  EPGSN, EPCRN, EPICSN, EPICVN, EPICMASKN  out  1 each  active-low source enables.
  GNT_2_0  out  3  one-hot grant, valid from DRIVE entry to end of ACK.
  ACK  out  1  one-cycle completion pulse to the granted requester.
  ERR  out  1  qualifies ACK: illegal source code.
  DATA_15_0  out  16  captured IDB word.
  BUSY  out  1  high whenever state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, DRIVE, DONE.
REQ-004 In IDLE with any REQ bit high, the block SHALL pick a winner by round-robin starting at pointer PTR, register its one-hot grant and its SEL code, and go to DRIVE next cycle.
REQ-005 In IDLE with REQ_2_0 = 0, the block SHALL stay in IDLE with all outputs at reset values except DATA_15_0, which holds.
REQ-006 In DRIVE, exactly one EP*N SHALL be low per the latched code; code 5 SHALL leave all EP*N high; codes 6..7 SHALL leave all EP*N high.
REQ-007 DRIVE SHALL last exactly DRIVE_CYC cycles, counted by a down-counter loaded with DRIVE_CYC-1 on DRIVE entry.
REQ-008 On the edge ending the last DRIVE cycle, DATA_15_0 SHALL load FIDBI_15_0 for codes 0..5; for codes 6..7 DATA_15_0 SHALL hold.
REQ-009 On that same edge the state SHALL go to DONE; all EP*N SHALL be high in DONE.
REQ-010 In DONE, ACK SHALL be 1 for exactly one cycle, ERR = 1 only for codes 6..7, and GNT_2_0 SHALL remain valid; the next state SHALL be IDLE.
REQ-011 PTR SHALL update on leaving DONE to (granted index + 1) mod 3.
REQ-012 Requesters hold REQ until ACK and drop it the cycle after; a REQ still high in IDLE SHALL be treated as a new request.
REQ-013 SEL inputs SHALL be sampled only at grant; changes during DRIVE/DONE SHALL have no effect.
REQ-014 Request-to-ACK latency SHALL be DRIVE_CYC + 1 cycles from the IDLE sampling edge; back-to-back throughput SHALL be one transfer per DRIVE_CYC + 2 cycles.
REQ-015 Requests changing in DRIVE/DONE SHALL not alter the current grant.
REQ-016 At most one EP*N SHALL ever be low, and no EP*N SHALL be low outside DRIVE.

Reset
REQ-017 RESETN low SHALL asynchronously force:
  - state IDLE
  - PTR = 0
  - counter = 0
  - GNT_2_0 = 0, ACK = 0, ERR = 0, BUSY = 0
  - all EP*N = 1
  - DATA_15_0 = 0
REQ-018 Reset asserted mid-DRIVE or mid-DONE SHALL abort the transfer with no ACK.
REQ-019 After RESETN is released, the first rising edge SHALL be treated as IDLE.

Verification
REQ-020 DRIVE_CYC=1, REQ=001, SEL0=1, FIDBI=16'hA5C3 -> EPCRN low 1 cycle, ACK at cycle 2, DATA=16'hA5C3, ERR=0, GNT=001.
REQ-021 DRIVE_CYC=1, REQ=111 held, all SEL=0 -> grant order 001, 010, 100, 001; ACKs spaced 3 cycles; EPGSN low once per transfer.
REQ-022 DRIVE_CYC=3, REQ=010, SEL1=4 -> EPICMASKN low 3 consecutive cycles; ACK 4 cycles after sampling edge; DATA = FIDBI value present on the last DRIVE cycle.
REQ-023 REQ=100, SEL2=7, DATA previously 16'h1234 -> no EP*N low; ACK=1 with ERR=1; DATA stays 16'h1234.
REQ-024 REQ=001, SEL0=5 -> all EP*N high throughout; DATA = FIDBI (external path); ERR=0.
REQ-025 DRIVE_CYC=2, RESETN pulsed low in the 2nd DRIVE cycle -> EPGSN high immediately; no ACK; DATA=0; next grant goes to requester 0.
